// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int BURST_LEN      = 4,
  parameter int ACCEPT_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           err_timeout,
  output logic                           uart_enable,
  output logic [DATA_BITS-1:0]           uart_tx_input,
  output logic                           uart_new_data,
  input  logic                           uart_ready
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ACCEPT_TIMEOUT) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, owner, pick, owner_next;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] timer;
  logic [NUM_REQ-1:0] pick_oh;
  // first active requester at or after rr_ptr; descending scan so the nearest one wins
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) pick = IW'((int'(rr_ptr) + k) % NUM_REQ);
    pick_oh = NUM_REQ'(1) << pick;
    owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end
  // arbitration and uart handshake sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      burst_cnt     <= '0;
      timer         <= '0;
      req_ack       <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      uart_enable   <= 1'b0;
      uart_tx_input <= '0;
      uart_new_data <= 1'b0;
    end else begin
      uart_enable <= 1'b1;
      req_ack     <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req && uart_ready) begin
          owner         <= pick;
          grant         <= pick_oh;
          req_ack       <= pick_oh;
          uart_tx_input <= req_data[int'(pick)*DATA_BITS +: DATA_BITS];
          uart_new_data <= 1'b1;
          burst_cnt     <= '0;
          timer         <= '0;
          busy          <= 1'b1;
          state         <= SEND;
        end
        SEND: if (!uart_ready) begin
          uart_new_data <= 1'b0;
          state         <= WAIT_DONE;
        end else if (timer == TW'(ACCEPT_TIMEOUT - 1)) begin
          err_timeout   <= 1'b1;
          uart_new_data <= 1'b0;
          grant         <= '0;
          rr_ptr        <= owner_next;
          busy          <= 1'b0;
          state         <= IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
        WAIT_DONE: if (uart_ready) begin
          if (req[owner] && burst_cnt < BW'(BURST_LEN - 1)) begin
            req_ack       <= NUM_REQ'(1) << owner;
            uart_tx_input <= req_data[int'(owner)*DATA_BITS +: DATA_BITS];
            uart_new_data <= 1'b1;
            burst_cnt     <= burst_cnt + 1'b1;
            timer         <= '0;
            state         <= SEND;
          end else begin
            grant     <= '0;
            rr_ptr    <= owner_next;
            burst_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized checks against a behavioural arbitration model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, BL = 4, TO = 16;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, req_ack, grant;
  logic [N*W-1:0] req_data;
  logic busy, err_timeout, uart_enable, uart_new_data, uart_ready;
  logic [W-1:0] uart_tx_input;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(W), .BURST_LEN(BL), .ACCEPT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack), .grant(grant),
    .busy(busy), .err_timeout(err_timeout), .uart_enable(uart_enable),
    .uart_tx_input(uart_tx_input), .uart_new_data(uart_new_data), .uart_ready(uart_ready));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 offering a byte, 2 frame on the wire
  int ph, rr, own, bcnt, tmr;
  logic [N-1:0] m_grant, m_ack;
  logic m_err, m_en, m_nd;
  logic [W-1:0] m_tx;

  function automatic int pick_rr(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    ph = 0; rr = 0; own = 0; bcnt = 0; tmr = 0;
    m_grant = '0; m_ack = '0; m_err = 1'b0; m_en = 1'b0; m_nd = 1'b0; m_tx = '0;
  endtask

  task automatic model_step();
    int p;
    m_ack = '0; m_err = 1'b0; m_en = 1'b1;
    p = pick_rr(req, rr);
    if (ph == 0) begin
      if (p >= 0 && uart_ready) begin
        own = p; m_grant = N'(1) << p; m_ack = m_grant; m_tx = req_data[p*W +: W];
        m_nd = 1'b1; bcnt = 0; tmr = 0; ph = 1;
      end
    end else if (ph == 1) begin
      if (!uart_ready) begin
        m_nd = 1'b0; ph = 2;
      end else if (tmr == TO - 1) begin
        m_err = 1'b1; m_nd = 1'b0; m_grant = '0; rr = (own + 1) % N; ph = 0;
      end else tmr++;
    end else if (uart_ready) begin
      if (req[own] && bcnt < BL - 1) begin
        m_ack = N'(1) << own; m_tx = req_data[own*W +: W]; m_nd = 1'b1; bcnt++; tmr = 0; ph = 1;
      end else begin
        m_grant = '0; rr = (own + 1) % N; bcnt = 0; ph = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("grant", 32'(grant), 32'(m_grant));
    chk("req_ack", 32'(req_ack), 32'(m_ack));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("uart_enable", 32'(uart_enable), 32'(m_en));
    chk("uart_new_data", 32'(uart_new_data), 32'(m_nd));
    chk("uart_tx_input", 32'(uart_tx_input), 32'(m_tx));
  endtask

  // uart stub: 0 ready, 1 counting to accept, 2 frame busy, 3 never accepts
  int sb = 0, scnt = 0;
  bit stuck_en = 0, force_stuck = 0, rnd = 0;
  task automatic stub_update();
    if (sb == 2) begin
      if (scnt == 0) begin uart_ready = 1'b1; sb = 0; end else scnt--;
    end else if (sb == 1) begin
      if (scnt == 0) begin uart_ready = 1'b0; sb = 2; scnt = $urandom_range(8, 2); end else scnt--;
    end else if (sb == 3) begin
      if (!m_nd) sb = 0;
    end else if (m_nd) begin
      if (force_stuck || (stuck_en && $urandom_range(9, 0) == 0)) sb = 3;
      else begin sb = 1; scnt = $urandom_range(2, 0); end
    end
  endtask

  task automatic req_update();
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        else req_data[i*W +: W] = 8'($urandom);
      end else if (!req[i] && $urandom_range(5, 0) == 0) begin
        req[i] = 1'b1;
        req_data[i*W +: W] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    stub_update();
    if (rnd) req_update();
  endtask

  task automatic run_until(input int phase, input string tag);
    for (int i = 0; i < 300 && ph != phase; i++) step();
    chk(tag, 32'(ph), 32'(phase));
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; req_data = 32'h44332211; uart_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_grant", 32'(grant), 32'h0);
    rst = 1'b0;
    step();
    chk("first_enable", 32'(uart_enable), 32'h1);
    chk("first_grant", 32'(grant), 32'h1);
    repeat (150) step();
    req = '0;
    run_until(0, "drain_idle");
    req = 4'b0100; req_data[2*W +: W] = 8'hA5;
    step();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_ack", 32'(req_ack), 32'h4);
    chk("single_data", 32'(uart_tx_input), 32'hA5);
    req = '0;
    run_until(0, "single_done");
    chk("single_release", 32'(grant), 32'h0);
    force_stuck = 1'b1;
    req = 4'b0010;
    step();
    force_stuck = 1'b0;
    chk("to_grant", 32'(grant), 32'h2);
    req[3] = 1'b1;
    repeat (TO - 1) step();
    chk("to_not_yet", 32'(err_timeout), 32'h0);
    step();
    chk("to_pulse", 32'(err_timeout), 32'h1);
    chk("to_release", 32'(grant), 32'h0);
    step();
    chk("to_next_grant", 32'(grant), 32'h8);
    run_until(2, "reach_wait");
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_nd", 32'(uart_new_data), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    model_reset();
    sb = 0; uart_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk("post_rst_grant", 32'(grant), 32'h2);
    rnd = 1'b1; stuck_en = 1'b1; req = '0;
    repeat (4000) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
